// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad scanner:
//                FSM state encoding, {row,col} -> hex decode table, row-drive
//                reset pattern and small column-pattern helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Scanner states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_t;

    // Row drive coming out of reset: row 0 selected (active low)
    localparam logic [3:0] ROWS_RESET = 4'b1110;

    // Hex code of each key, indexed by {row, col}
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Active-low one-hot pattern with only bit idx at 0
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        row_drive = ~(4'b0001 << idx);
    endfunction

    // True when exactly one column reads low
    function automatic logic single_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    // Index of the low column; only meaningful when single_low(v) holds
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1101: low_index = 2'd1;
            4'b1011: low_index = 2'd2;
            4'b0111: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_debounce_scan_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Parameterized-width two-flop synchronizer. Clears to all
//                ones so idle (pulled-up) keypad columns read as released.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/keypad_debounce_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce_scan
//  Description : 4x4 matrix keypad row scanner with single-key debounce.
//                Emits the hex code of an accepted key together with a
//                one-cycle key_valid strobe; other keys are ignored while a
//                key is held.
//  Options     : KEYPAD_REPEAT_EN - auto-repeat strobes while a key is held
//                (adds REPEAT_DELAY / REPEAT_RATE, both in ticks).
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce_scan #(
    parameter int SCAN_DIV     = 48000,
    parameter int DB_COUNT     = 20
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key,
    output logic       key_valid
);

    import keypad_pkg::*;

    localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_cnt_w = $clog2(DB_COUNT + 1);

    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_db_target = c_cnt_w'(DB_COUNT);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

`ifdef KEYPAD_REPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_rep_w   = $clog2(c_rep_max + 1);

    localparam logic [c_rep_w-1:0] c_rep_delay = c_rep_w'(REPEAT_DELAY);
    localparam logic [c_rep_w-1:0] c_rep_rate  = c_rep_w'(REPEAT_RATE);
`endif

    // Tick generation
    logic [c_div_w-1:0] r_div;
    logic               w_tick;

    // Synchronized columns
    logic [3:0]         w_cs;

    // Scanner state
    kp_state_t          r_state;
    kp_state_t          w_state_nxt;
    logic [1:0]         r_row_idx;
    logic [1:0]         w_row_nxt;
    logic [1:0]         w_row_adv;
    logic [1:0]         r_col;
    logic [1:0]         w_col_nxt;
    logic [1:0]         w_scan_col;
    logic [c_cnt_w-1:0] r_db_cnt;
    logic [c_cnt_w-1:0] w_db_nxt;
    logic [c_cnt_w-1:0] w_db_inc;
    logic [3:0]         r_rows;
    logic [3:0]         r_key;
    logic [3:0]         w_key_nxt;
    logic               r_kv;
    logic               w_kv_nxt;
    logic               w_only_latched;
    logic               w_latched_high;

`ifdef KEYPAD_REPEAT_EN
    logic [c_rep_w-1:0] r_rep_cnt;
    logic [c_rep_w-1:0] w_rep_nxt;
    logic [c_rep_w-1:0] w_rep_inc;
    logic               r_rep_armed;
    logic               w_rep_armed_nxt;
`endif

    sync2 #(
        .WIDTH (4)
    ) u_cols_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (cols),
        .o_q   (w_cs)
    );

    assign w_tick         = (r_div == c_div_last);
    assign w_row_adv      = r_row_idx + 2'd1;
    assign w_scan_col     = low_index(w_cs);
    assign w_only_latched = (w_cs == row_drive(r_col));
    assign w_latched_high = w_cs[r_col];
    assign w_db_inc       = (r_db_cnt == '1) ? r_db_cnt : r_db_cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
    assign w_rep_inc      = r_rep_cnt + 1'b1;
`endif

    // Free-running sample/dwell divider, wraps at SCAN_DIV-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // State, row/column latches, debounce counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SCAN;
            r_row_idx   <= 2'd0;
            r_col       <= 2'd0;
            r_db_cnt    <= '0;
            r_rows      <= ROWS_RESET;
            r_key       <= 4'h0;
            r_kv        <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_row_idx   <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_db_cnt    <= w_db_nxt;
            r_rows      <= row_drive(w_row_nxt);
            r_key       <= w_key_nxt;
            r_kv        <= w_kv_nxt;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= w_rep_nxt;
            r_rep_armed <= w_rep_armed_nxt;
`endif
        end
    end

    // Next-state logic; every decision is taken on a sample tick only
    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row_idx;
        w_col_nxt       = r_col;
        w_db_nxt        = r_db_cnt;
        w_key_nxt       = r_key;
        w_kv_nxt        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_nxt       = r_rep_cnt;
        w_rep_armed_nxt = r_rep_armed;
`endif
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (single_low(w_cs)) begin
                        w_col_nxt = w_scan_col;
                        if (c_cnt_one == c_db_target) begin
                            // Single-sample debounce: accept immediately
                            w_key_nxt   = KEY_MAP[{r_row_idx, w_scan_col}];
                            w_kv_nxt    = 1'b1;
                            w_db_nxt    = '0;
                            w_state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
                            w_rep_nxt       = '0;
                            w_rep_armed_nxt = 1'b0;
`endif
                        end else begin
                            w_db_nxt    = c_cnt_one;
                            w_state_nxt = PRESS_DB;
                        end
                    end else begin
                        // None or several columns low: keep scanning
                        w_row_nxt = w_row_adv;
                    end
                end

                PRESS_DB: begin
                    if (w_only_latched) begin
                        w_db_nxt = w_db_inc;
                        if (w_db_inc == c_db_target) begin
                            w_key_nxt   = KEY_MAP[{r_row_idx, r_col}];
                            w_kv_nxt    = 1'b1;
                            w_db_nxt    = '0;
                            w_state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
                            w_rep_nxt       = '0;
                            w_rep_armed_nxt = 1'b0;
`endif
                        end
                    end else begin
                        // Bounce or extra key: abandon and move on
                        w_db_nxt    = '0;
                        w_row_nxt   = w_row_adv;
                        w_state_nxt = SCAN;
                    end
                end

                HELD: begin
                    if (w_latched_high) begin
                        if (c_cnt_one == c_db_target) begin
                            w_db_nxt    = '0;
                            w_row_nxt   = w_row_adv;
                            w_state_nxt = SCAN;
                        end else begin
                            w_db_nxt    = c_cnt_one;
                            w_state_nxt = REL_DB;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (!r_rep_armed) begin
                        // Waiting out the initial repeat delay
                        if (w_rep_inc == c_rep_delay) begin
                            w_kv_nxt        = 1'b1;
                            w_rep_nxt       = '0;
                            w_rep_armed_nxt = 1'b1;
                        end else begin
                            w_rep_nxt = w_rep_inc;
                        end
                    end else begin
                        // Steady repeat cadence
                        if (w_rep_inc == c_rep_rate) begin
                            w_kv_nxt  = 1'b1;
                            w_rep_nxt = '0;
                        end else begin
                            w_rep_nxt = w_rep_inc;
                        end
                    end
`endif
                end

                REL_DB: begin
                    if (w_latched_high) begin
                        w_db_nxt = w_db_inc;
                        if (w_db_inc == c_db_target) begin
                            w_db_nxt    = '0;
                            w_row_nxt   = w_row_adv;
                            w_state_nxt = SCAN;
                        end
                    end else begin
                        // Contact closed again: still the same press
                        w_db_nxt    = '0;
                        w_state_nxt = HELD;
                    end
                end

                default: begin
                    w_db_nxt    = '0;
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    assign rows      = r_rows;
    assign key       = r_key;
    assign key_valid = r_kv;

endmodule : keypad_debounce_scan
`default_nettype wire

// File: tb/tb_keypad_debounce_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_debounce_scan
//  Description : Self-checking bench for keypad_debounce_scan with a
//                behavioural 4x4 keypad (SCAN_DIV=4, DB_COUNT=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_debounce_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB_COUNT = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key;
    logic       key_valid;

    // pmask[r][c] = 1 means the key at row r, column c is pressed
    logic [3:0] pmask [4] = '{default: 4'h0};

    int cyc;
    int errors = 0;
    int checks = 0;
    int q_base = 0;
    int sq_cyc [$];
    logic [3:0] sq_key [$];

    typedef struct {
        int         cyc;
        logic [3:0] rows;
        logic [3:0] key;
        logic       kv;
    } vec_t;

    vec_t t1 [10];

    always #5 clk = ~clk;

    keypad_debounce_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DB_COUNT     (DB_COUNT)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key       (key),
        .key_valid (key_valid)
    );

    // Behavioural keypad: a pressed key pulls its column low while its row is driven
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pmask[r][c] && !rows[r]) cols[c] = 1'b0;
            end
        end
    end

    // Cycle index: posedges since the last reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Strobe recorder
    always @(negedge clk) begin
        if (reset && key_valid) begin
            sq_cyc.push_back(cyc);
            sq_key.push_back(key);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc < k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc != k) begin
            errors++;
            $display("FAIL wait_cyc: actual=%0d required=%0d", cyc, k);
        end
    endtask

    task automatic expect_at(input string tag, input int k, input logic [3:0] er,
                             input logic [3:0] ek, input logic ev);
        wait_cyc(k);
        chk($sformatf("%s_rows@%0d", tag, k), 32'(rows), 32'(er));
        chk($sformatf("%s_key@%0d", tag, k), 32'(key), 32'(ek));
        chk($sformatf("%s_kv@%0d", tag, k), 32'(key_valid), 32'(ev));
    endtask

    task automatic chk_strobes(input string tag, input int n, input int exp_c [6],
                               input logic [3:0] exp_k);
        int got;
        got = sq_cyc.size() - q_base;
        chk($sformatf("%s_strobe_count", tag), got, n);
        for (int i = 0; i < n && i < got; i++) begin
            chk($sformatf("%s_strobe%0d_cyc", tag, i), sq_cyc[q_base + i], exp_c[i]);
            chk($sformatf("%s_strobe%0d_key", tag, i), 32'(sq_key[q_base + i]), 32'(exp_k));
        end
    endtask

    task automatic do_reset(input logic [3:0] m0, input logic [3:0] m1,
                            input logic [3:0] m2, input logic [3:0] m3);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        pmask[0] = m0;
        pmask[1] = m1;
        pmask[2] = m2;
        pmask[3] = m3;
        q_base   = sq_cyc.size();
        reset    = 1'b1;
    endtask

    initial begin
        int exp_c [6];

        t1 = '{
            '{0,  4'b1110, 4'h0, 1'b0},
            '{1,  4'b1110, 4'h0, 1'b0},
            '{3,  4'b1110, 4'h0, 1'b0},
            '{4,  4'b1101, 4'h0, 1'b0},
            '{7,  4'b1101, 4'h0, 1'b0},
            '{8,  4'b1011, 4'h0, 1'b0},
            '{11, 4'b1011, 4'h0, 1'b0},
            '{12, 4'b0111, 4'h0, 1'b0},
            '{15, 4'b0111, 4'h0, 1'b0},
            '{16, 4'b1110, 4'h0, 1'b0}
        };

        // 1. reset values and idle row rotation
        do_reset(4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            expect_at("t1", t1[i].cyc, t1[i].rows, t1[i].key, t1[i].kv);
        end
        exp_c = '{0, 0, 0, 0, 0, 0};
        chk_strobes("t1", 0, exp_c, 4'h0);

        // 2. key 6 (row 1, column 2): one strobe, row frozen until release
        do_reset(4'h0, 4'b0100, 4'h0, 4'h0);
        expect_at("t2", 8,  4'b1101, 4'h0, 1'b0);
        expect_at("t2", 15, 4'b1101, 4'h0, 1'b0);
        expect_at("t2", 16, 4'b1101, 4'h6, 1'b1);
        expect_at("t2", 17, 4'b1101, 4'h6, 1'b0);
        expect_at("t2", 20, 4'b1101, 4'h6, 1'b0);
        pmask[1] = 4'h0;
        expect_at("t2", 31, 4'b1101, 4'h6, 1'b0);
        expect_at("t2", 32, 4'b1011, 4'h6, 1'b0);
        exp_c = '{16, 0, 0, 0, 0, 0};
        chk_strobes("t2", 1, exp_c, 4'h6);

        // 3. key 1 bounces on first contact, accepted on a later row-0 visit
        do_reset(4'b0001, 4'h0, 4'h0, 4'h0);
        expect_at("t3", 4, 4'b1110, 4'h0, 1'b0);
        pmask[0] = 4'h0;
        expect_at("t3", 8, 4'b1101, 4'h0, 1'b0);
        pmask[0] = 4'b0001;
        expect_at("t3", 24, 4'b1110, 4'h0, 1'b0);
        expect_at("t3", 32, 4'b1110, 4'h1, 1'b1);
        expect_at("t3", 33, 4'b1110, 4'h1, 1'b0);
        pmask[0] = 4'h0;
        exp_c = '{32, 0, 0, 0, 0, 0};
        chk_strobes("t3", 1, exp_c, 4'h1);

        // 4. hold 7, add 9 in the same row: only 7 is reported
        do_reset(4'h0, 4'h0, 4'b0001, 4'h0);
        expect_at("t4", 12, 4'b1011, 4'h0, 1'b0);
        expect_at("t4", 20, 4'b1011, 4'h7, 1'b1);
        wait_cyc(21);
        pmask[2] = 4'b0101;
        expect_at("t4", 28, 4'b1011, 4'h7, 1'b0);
        wait_cyc(29);
        pmask[2] = 4'b0100;
        expect_at("t4", 39, 4'b1011, 4'h7, 1'b0);
        expect_at("t4", 40, 4'b0111, 4'h7, 1'b0);
        wait_cyc(41);
        pmask[2] = 4'h0;
        expect_at("t4", 60, 4'b1110, 4'h7, 1'b0);
        exp_c = '{20, 0, 0, 0, 0, 0};
        chk_strobes("t4", 1, exp_c, 4'h7);

        // 5a. two columns of row 3 together are ignored
        do_reset(4'h0, 4'h0, 4'h0, 4'b0101);
        expect_at("t5a", 16, 4'b1110, 4'h0, 1'b0);
        expect_at("t5a", 20, 4'b1101, 4'h0, 1'b0);
        expect_at("t5a", 32, 4'b1110, 4'h0, 1'b0);
        exp_c = '{0, 0, 0, 0, 0, 0};
        chk_strobes("t5a", 0, exp_c, 4'h0);

        // 5b. reset asserted during press debounce of key 5
        do_reset(4'h0, 4'b0010, 4'h0, 4'h0);
        expect_at("t5b", 13, 4'b1101, 4'h0, 1'b0);
        reset = 1'b0;
        #1;
        chk("t5b_rows_async", 32'(rows), 32'(4'b1110));
        chk("t5b_kv_async", 32'(key_valid), 32'(1'b0));
        repeat (6) @(negedge clk);
        chk("t5b_rows_held", 32'(rows), 32'(4'b1110));
        chk("t5b_key_held", 32'(key), 32'(4'h0));
        chk("t5b_kv_held", 32'(key_valid), 32'(1'b0));
        pmask[1] = 4'h0;
        exp_c = '{0, 0, 0, 0, 0, 0};
        chk_strobes("t5b", 0, exp_c, 4'h0);

        // 6. hold key 0 for 12 ticks after acceptance
        do_reset(4'h0, 4'h0, 4'h0, 4'b0010);
        expect_at("t6", 23, 4'b0111, 4'h0, 1'b0);
        expect_at("t6", 24, 4'b0111, 4'h0, 1'b1);
        wait_cyc(72);
        pmask[3] = 4'h0;
        expect_at("t6", 90, 4'b1101, 4'h0, 1'b0);
`ifdef KEYPAD_REPEAT_EN
        exp_c = '{24, 44, 52, 60, 68, 0};
        chk_strobes("t6", 5, exp_c, 4'h0);
`else
        exp_c = '{24, 0, 0, 0, 0, 0};
        chk_strobes("t6", 1, exp_c, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_keypad_debounce_scan
`default_nettype wire
